cbx_param_dbuf: RTL and testbench

//  Parametrised X-direction connection block with double-buffered configuration.

---
 rtl/cbx_param_dbuf.sv | 108 ++++++++++
 tb/tb_cbx_param_dbuf.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cbx_param_dbuf.sv
// rtl/cbx_param_dbuf.sv - X-direction connection block with scan-loaded, double-buffered mux selects
module cbx_param_dbuf #(
    parameter int CHAN_W     = 30,
    parameter int NUM_IPIN   = 4,
    parameter int MUX_SIZE   = 12,
    parameter int TAP_STRIDE = 3,
    localparam int SEL_W     = $clog2(MUX_SIZE),
    localparam int TOTAL     = NUM_IPIN * SEL_W,
    localparam int CNT_W     = $clog2(TOTAL + 1)
) (
    input  logic                prog_clk,
    input  logic                prog_reset_n,
    input  logic                ccff_head,
    input  logic                ccff_en,
    input  logic                cfg_commit,
    input  logic [CHAN_W-1:0]   chanx_left_in,
    input  logic [CHAN_W-1:0]   chanx_right_in,
    output logic [CHAN_W-1:0]   chanx_left_out,
    output logic [CHAN_W-1:0]   chanx_right_out,
    output logic [NUM_IPIN-1:0] ipin_out,
    output logic                ccff_tail,
    output logic [CNT_W-1:0]    cfg_count,
    output logic                cfg_full,
    output logic                cfg_err
);

    localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL);

    // Index 0 is the chain entry; ipin i owns [i*SEL_W +: SEL_W] with its MSB at the lowest index.
    logic [0:TOTAL-1] shadow_q, shadow_d;
    logic [0:TOTAL-1] active_q, active_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic             commit_ok;

    assign commit_ok = cfg_commit && (count_q == TOTAL_C);

    always_comb begin
        shadow_d = shadow_q;
        if (ccff_en) begin
            shadow_d = {ccff_head, shadow_q[0:TOTAL-2]};
        end
    end

    always_comb begin
        active_d = active_q;
        if (commit_ok) begin
            active_d = shadow_q;
        end
    end

    // The commit clears first so a same-edge shift leaves the count at 1.
    always_comb begin
        count_d = count_q;
        if (commit_ok) begin
            count_d = '0;
        end
        if (ccff_en && (count_d != TOTAL_C)) begin
            count_d = count_d + 1'b1;
        end
    end

    always_comb begin
        err_d = err_q;
        if (cfg_commit) begin
            err_d = !commit_ok;
        end
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            shadow_q <= '0;
            active_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    assign chanx_left_out  = chanx_right_in;
    assign chanx_right_out = chanx_left_in;
    assign ccff_tail       = shadow_q[TOTAL-1];
    assign cfg_count       = count_q;
    assign cfg_full        = (count_q == TOTAL_C);
    assign cfg_err         = err_q;

    for (genvar i = 0; i < NUM_IPIN; i++) begin : g_ipin
        // Tap vector is padded to a power of two so out-of-range selects read a zero.
        logic [(1<<SEL_W)-1:0] taps;
        logic [SEL_W-1:0]      sel;

        always_comb begin
            taps = '0;
            for (int k = 0; k < MUX_SIZE / 2; k++) begin
                taps[2*k]   = chanx_left_in[(i + k * TAP_STRIDE) % CHAN_W];
                taps[2*k+1] = chanx_right_in[(i + k * TAP_STRIDE) % CHAN_W];
            end
        end

        assign sel         = active_q[i*SEL_W +: SEL_W];
        assign ipin_out[i] = taps[sel];
    end

endmodule

// File: tb/tb_cbx_param_dbuf.sv
// tb/tb_cbx_param_dbuf.sv - self-checking bench for cbx_param_dbuf
module tb_cbx_param_dbuf;

    localparam int CHAN_W     = 30;
    localparam int NUM_IPIN   = 4;
    localparam int MUX_SIZE   = 12;
    localparam int TAP_STRIDE = 3;
    localparam int SEL_W      = 4;
    localparam int TOTAL      = 16;
    localparam int CNT_W      = 5;

    logic                prog_clk = 1'b0;
    logic                prog_reset_n;
    logic                ccff_head;
    logic                ccff_en;
    logic                cfg_commit;
    logic [CHAN_W-1:0]   left_in;
    logic [CHAN_W-1:0]   right_in;
    logic [CHAN_W-1:0]   left_out;
    logic [CHAN_W-1:0]   right_out;
    logic [NUM_IPIN-1:0] ipin_out;
    logic                ccff_tail;
    logic [CNT_W-1:0]    cfg_count;
    logic                cfg_full;
    logic                cfg_err;

    int checks   = 0;
    int failures = 0;

    cbx_param_dbuf #(
        .CHAN_W(CHAN_W), .NUM_IPIN(NUM_IPIN), .MUX_SIZE(MUX_SIZE), .TAP_STRIDE(TAP_STRIDE)
    ) dut (
        .prog_clk       (prog_clk),
        .prog_reset_n   (prog_reset_n),
        .ccff_head      (ccff_head),
        .ccff_en        (ccff_en),
        .cfg_commit     (cfg_commit),
        .chanx_left_in  (left_in),
        .chanx_right_in (right_in),
        .chanx_left_out (left_out),
        .chanx_right_out(right_out),
        .ipin_out       (ipin_out),
        .ccff_tail      (ccff_tail),
        .cfg_count      (cfg_count),
        .cfg_full       (cfg_full),
        .cfg_err        (cfg_err)
    );

    always #5 prog_clk = ~prog_clk;

    // Reference model: bit history (hist[0] = newest), committed selects, counter, error flag.
    bit hist[$];
    int sel_m[NUM_IPIN];
    int cnt_m;
    bit err_m;

    typedef struct {
        logic [15:0]       sels;
        logic [CHAN_W-1:0] left;
        logic [CHAN_W-1:0] right;
        logic [3:0]        exp_ipin;
    } vec_t;

    vec_t vt[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic void model_reset();
        hist.delete();
        repeat (TOTAL) hist.push_back(1'b0);
        foreach (sel_m[i]) sel_m[i] = 0;
        cnt_m = 0;
        err_m = 1'b0;
    endfunction

    function automatic void model_step(input bit en, input bit head, input bit commit);
        if (commit) begin
            if (cnt_m == TOTAL) begin
                for (int i = 0; i < NUM_IPIN; i++) begin
                    sel_m[i] = 0;
                    for (int b = 0; b < SEL_W; b++) sel_m[i] = sel_m[i] * 2 + int'(hist[i*SEL_W+b]);
                end
                cnt_m = 0;
                err_m = 1'b0;
            end else begin
                err_m = 1'b1;
            end
        end
        if (en) begin
            hist.push_front(head);
            void'(hist.pop_back());
            if (cnt_m < TOTAL) cnt_m++;
        end
    endfunction

    function automatic logic [NUM_IPIN-1:0] model_ipin();
        logic [NUM_IPIN-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_IPIN; i++) begin
            if (sel_m[i] < MUX_SIZE) begin
                int trk;
                trk  = (i + (sel_m[i] / 2) * TAP_STRIDE) % CHAN_W;
                r[i] = (sel_m[i] % 2 == 1) ? right_in[trk] : left_in[trk];
            end
        end
        return r;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".ipin"},  64'(ipin_out),  64'(model_ipin()));
        chk({tag, ".tail"},  64'(ccff_tail), 64'(hist[TOTAL-1]));
        chk({tag, ".count"}, 64'(cfg_count), 64'(cnt_m));
        chk({tag, ".full"},  64'(cfg_full),  64'(cnt_m == TOTAL));
        chk({tag, ".err"},   64'(cfg_err),   64'(err_m));
        chk({tag, ".lout"},  64'(left_out),  64'(right_in));
        chk({tag, ".rout"},  64'(right_out), 64'(left_in));
    endtask

    task automatic cyc(input bit en, input bit head, input bit commit, input string tag);
        ccff_en    = en;
        ccff_head  = head;
        cfg_commit = commit;
        @(posedge prog_clk);
        model_step(en, head, commit);
        #1;
        ccff_en    = 1'b0;
        cfg_commit = 1'b0;
        check_model(tag);
    endtask

    // Chain order: ipin NUM_IPIN-1 first, each select LSB first.
    task automatic shift_sels(input logic [15:0] sels);
        for (int i = NUM_IPIN - 1; i >= 0; i--)
            for (int b = 0; b < SEL_W; b++)
                cyc(1'b1, sels[i*SEL_W+b], 1'b0, "load");
    endtask

    task automatic load_sels(input logic [15:0] sels);
        shift_sels(sels);
        chk("load.full_before", 64'(cfg_full), 64'd1);
        chk("load.count_before", 64'(cfg_count), 64'd16);
        cyc(1'b0, 1'b0, 1'b1, "commit");
        chk("commit.count_after", 64'(cfg_count), 64'd0);
        chk("commit.err_after", 64'(cfg_err), 64'd0);
    endtask

    initial begin
        bit bits[20];

        vt[0] = '{16'h5000, 30'h0,            30'h200,           4'b1000};
        vt[1] = '{16'h5000, 30'h7,            30'h0,             4'b0111};
        vt[2] = '{16'h5000, 30'h3FFF_FFFF,    30'h0,             4'b0111};
        vt[3] = '{16'hB21D, 30'h3FFF_FFFF,    30'h3FFF_FFFF,     4'b1110};
        vt[4] = '{16'hB21D, 30'h20,           30'h0,             4'b0100};
        vt[5] = '{16'hB21D, 30'h0,            30'h0004_0002,     4'b1010};
        vt[6] = '{16'h00FC, 30'h3FFF_FFFF,    30'h3FFF_FFFF,     4'b1100};

        // Reset state
        prog_reset_n = 1'b0;
        ccff_head    = 1'b0;
        ccff_en      = 1'b0;
        cfg_commit   = 1'b0;
        left_in      = 30'h2;
        right_in     = '0;
        model_reset();
        #12;
        chk("reset.ipin",  64'(ipin_out),  64'b0010);
        chk("reset.count", 64'(cfg_count), 64'd0);
        chk("reset.full",  64'(cfg_full),  64'd0);
        chk("reset.err",   64'(cfg_err),   64'd0);
        chk("reset.tail",  64'(ccff_tail), 64'd0);
        check_model("reset");
        #1 prog_reset_n = 1'b1;

        // Table-driven mux vectors, each loaded and committed
        for (int r = 0; r < 7; r++) begin
            left_in  = vt[r].left;
            right_in = vt[r].right;
            load_sels(vt[r].sels);
            chk($sformatf("vec%0d.ipin", r), 64'(ipin_out), 64'(vt[r].exp_ipin));
        end

        // Rejected commit after 10 bits, then complete the load
        for (int j = 0; j < 10; j++) cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)) , 1'b0, "partial");
        while (cnt_m < 10) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, "partial_fill");
        cyc(1'b0, 1'b0, 1'b1, "reject");
        chk("reject.err",   64'(cfg_err),   64'd1);
        chk("reject.count", 64'(cfg_count), 64'd10);
        chk("reject.ipin",  64'(ipin_out),  64'b1100);
        for (int j = 0; j < 6; j++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, "finish");
        cyc(1'b0, 1'b0, 1'b1, "accept");
        chk("accept.err",   64'(cfg_err),   64'd0);
        chk("accept.count", 64'(cfg_count), 64'd0);

        // Commit and shift on the same edge
        left_in  = '0;
        right_in = 30'h200;
        shift_sels(16'h5000);
        cyc(1'b1, 1'b1, 1'b1, "simul");
        chk("simul.count", 64'(cfg_count), 64'd1);
        chk("simul.err",   64'(cfg_err),   64'd0);
        chk("simul.ipin",  64'(ipin_out),  64'b1000);

        // Async reset mid-shift, between clock edges
        for (int j = 0; j < 6; j++) cyc(1'b1, 1'b1, 1'b0, "pre_rst");
        chk("pre_rst.count", 64'(cfg_count), 64'd7);
        left_in = 30'h5;
        #2 prog_reset_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst.count", 64'(cfg_count), 64'd0);
        chk("async_rst.tail",  64'(ccff_tail), 64'd0);
        chk("async_rst.ipin",  64'(ipin_out),  64'b0101);
        check_model("async_rst");
        #2 prog_reset_n = 1'b1;

        // Chain echo: tail shows the bit shifted 16 shifts earlier
        for (int j = 0; j < 20; j++) begin
            bits[j] = 1'($urandom_range(0, 1));
            cyc(1'b1, bits[j], 1'b0, "echo");
            chk($sformatf("echo%0d.tail", j), 64'(ccff_tail), (j >= TOTAL - 1) ? 64'(bits[j-TOTAL+1]) : 64'd0);
        end

        // Randomised traffic against the model
        for (int n = 0; n < 1500; n++) begin
            left_in  = CHAN_W'($urandom);
            right_in = CHAN_W'($urandom);
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 9) == 0), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
